// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - 8-digit multiplexed seven-segment scanner with per-frame snapshot
// Brightness PWM within each digit slot, leading-zero blanking and decimal-point mask.
module seg7_scan_display #(
  parameter int DIV   = 100000,
  parameter int CNT_W = 17
) (
  input  logic        clk,
  input  logic        CLR,
  input  logic [31:0] display,
  input  logic [7:0]  dp_en,
  input  logic [2:0]  brightness,
  input  logic        blank_lz,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        frame_done
);

  localparam int               SLOT     = DIV / 8;
  localparam int               TH_W     = CNT_W + 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;

  logic [31:0]      sh_word;
  logic [7:0]       sh_dp;
  logic [2:0]       sh_bright;
  logic             sh_blz;

  logic             slot_end;
  logic             frame_end;

  logic [3:0]       nibble;
  logic [7:0]       zero_from;
  logic             lz_blank;
  logic [TH_W-1:0]  thresh;
  logic             lit;

  logic [7:0]       an_d;
  logic [6:0]       seg_d;
  logic             dp_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == 3'd7);

  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CNT_W'(1);
      if (slot_end)
        idx <= idx + 3'd1;
    end
  end

  // The shadow is only loaded on the last cycle of a frame, so a digit never tears.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      sh_word   <= '0;
      sh_dp     <= '0;
      sh_bright <= '0;
      sh_blz    <= 1'b0;
    end else if (frame_end) begin
      sh_word   <= display;
      sh_dp     <= dp_en;
      sh_bright <= brightness;
      sh_blz    <= blank_lz;
    end
  end

  always_comb begin
    nibble       = sh_word[{idx, 2'b00} +: 4];
    zero_from    = '0;
    zero_from[7] = (sh_word[31:28] == 4'h0);
    for (int i = 6; i >= 0; i--)
      zero_from[i] = zero_from[i+1] && (sh_word[4*i +: 4] == 4'h0);
    lz_blank = sh_blz && (idx != 3'd0) && zero_from[idx];
    thresh   = (TH_W'(sh_bright) + TH_W'(1)) * TH_W'(SLOT);
    lit      = (TH_W'(cnt) < thresh) && !lz_blank;
  end

  always_comb begin
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (lit) begin
      an_d  = ~(8'b1 << idx);
      seg_d = hex7(nibble);
      dp_d  = ~sh_dp[idx];
    end
  end

  // Every output is registered: no input reaches a pin combinationally.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      AN         <= 8'hFF;
      SEG        <= 7'h7F;
      DP         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      AN         <= an_d;
      SEG        <= seg_d;
      DP         <= dp_d;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - directed self-checking bench for seg7_scan_display (DIV=8)
module tb_seg7_scan_display;

  logic        clk;
  logic        CLR;
  logic [31:0] display;
  logic [7:0]  dp_en;
  logic [2:0]  brightness;
  logic        blank_lz;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  logic        DP;
  logic        frame_done;

  int total;
  int bad;
  int n;

  seg7_scan_display #(.DIV(8), .CNT_W(3)) dut (
    .clk        (clk),
    .CLR        (CLR),
    .display    (display),
    .dp_en      (dp_en),
    .brightness (brightness),
    .blank_lz   (blank_lz),
    .AN         (AN),
    .SEG        (SEG),
    .DP         (DP),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[v];
  endfunction

  // Counts edges from reset release until the first frame_done; also checks
  // the zero snapshot of the first frame (digit 0 lit for one cycle only).
  task automatic wait_first_frame(output int cycles);
    cycles = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      cycles = i;
      if (i == 1) begin
        chk("first_an0", AN, 8'hFE);
        chk("first_seg0", SEG, 7'b1000000);
      end
      if (i == 2) chk("first_an_off", AN, 8'hFF);
      if (i == 9) chk("first_an1", AN, 8'hFD);
      if (frame_done) break;
    end
    chk("fd_seen", frame_done, 1'b1);
  endtask

  // Checks one whole frame against the snapshot (w,dp,br,blz); at k==20 the
  // inputs are changed to the next frame's values, which must not show yet.
  task automatic run_frame(input string name,
                           input logic [31:0] w, input logic [7:0] dp,
                           input logic [2:0] br, input logic blz,
                           input logic [31:0] nw, input logic [7:0] ndp,
                           input logic [2:0] nbr, input logic nblz);
    int d, c, bri;
    logic lz, on;
    logic [7:0] ean;
    logic [6:0] eseg;
    logic edp;
    bri = int'(br);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      d    = k / 8;
      c    = k % 8;
      lz   = blz && (d != 0) && ((w >> (4 * d)) == 32'h0);
      on   = (c < bri + 1) && !lz;
      ean  = on ? ~(8'b1 << d) : 8'hFF;
      eseg = on ? seg_of(w[4*d +: 4]) : 7'h7F;
      edp  = on ? ~dp[d] : 1'b1;
      chk($sformatf("%s_an_k%0d", name, k), AN, ean);
      chk($sformatf("%s_seg_k%0d", name, k), SEG, eseg);
      chk($sformatf("%s_dp_k%0d", name, k), DP, edp);
      chk($sformatf("%s_fd_k%0d", name, k), frame_done, (k == 63));
      if (k == 20) begin
        display    = nw;
        dp_en      = ndp;
        brightness = nbr;
        blank_lz   = nblz;
      end
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    CLR        = 1'b1;
    display    = 32'h0;
    dp_en      = 8'h0;
    brightness = 3'd0;
    blank_lz   = 1'b0;
    #1 CLR = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an", AN, 8'hFF);
    chk("rst_seg", SEG, 7'h7F);
    chk("rst_dp", DP, 1'b1);
    chk("rst_fd", frame_done, 1'b0);
    CLR = 1'b1;
    wait_first_frame(n);
    chk("first_fd_latency", n, 64);

    run_frame("zero",  32'h0, 8'h00, 3'd0, 1'b0, 32'h12345678, 8'h00, 3'd7, 1'b0);
    run_frame("hex",   32'h12345678, 8'h00, 3'd7, 1'b0, 32'hFFFFFFFF, 8'h00, 3'd7, 1'b0);
    run_frame("allf",  32'hFFFFFFFF, 8'h00, 3'd7, 1'b0, 32'h00000A30, 8'h00, 3'd7, 1'b1);
    run_frame("lz",    32'h00000A30, 8'h00, 3'd7, 1'b1, 32'h0, 8'h00, 3'd7, 1'b1);
    run_frame("lz0",   32'h0, 8'h00, 3'd7, 1'b1, 32'h12345678, 8'h81, 3'd1, 1'b0);
    run_frame("pwm",   32'h12345678, 8'h81, 3'd1, 1'b0, 32'h12345678, 8'h81, 3'd1, 1'b0);

    repeat (9) @(negedge clk);
    chk("pre_rst_an", AN, 8'hFD);
    #2 CLR = 1'b0;
    #1;
    chk("async_an", AN, 8'hFF);
    chk("async_seg", SEG, 7'h7F);
    chk("async_dp", DP, 1'b1);
    chk("async_fd", frame_done, 1'b0);
    repeat (2) @(negedge clk);
    chk("held_an", AN, 8'hFF);
    CLR = 1'b1;
    wait_first_frame(n);
    chk("rerst_fd_latency", n, 64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
